// File: rtl/scrypt_scratch_arbiter.sv
// scrypt_scratch_arbiter
//   Shares the single scratchpad SRAM between the scrypt_smix core (port A)
//   and the host/debug loader (port B). Round-robin arbitration with optional
//   burst locking, one SRAM access per cycle, registered read return.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   {a,b}_req/we/lock          per-port request, 1=write/0=read, keep-ownership
//   {a,b}_addr/wdata           per-port address and write data
//   {a,b}_grant                access performed this cycle (combinational)
//   {a,b}_rvalid/rdata         read return, one cycle after a granted read
//   scratch_read/write         SRAM read/write enable
//   scratch_addr/in            SRAM address / write data (hold when idle)
//   scratch_out                SRAM read data, combinational from address
//
// Optional feature (macro SCRYPT_SCRATCH_ARB_STATS_EN):
//   a_grant_cnt, b_grant_cnt   grants per port (wrap at 2^32)
//   conflict_cnt               cycles with both requests high
module scrypt_scratch_arbiter #(
    parameter int ADDR_BITS = 17,
    parameter int DATA_BITS = 1024,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic                 a_lock,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [DATA_BITS-1:0] a_wdata,
    output logic                 a_grant,
    output logic                 a_rvalid,
    output logic [DATA_BITS-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic                 b_lock,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [DATA_BITS-1:0] b_wdata,
    output logic                 b_grant,
    output logic                 b_rvalid,
    output logic [DATA_BITS-1:0] b_rdata,
`ifdef SCRYPT_SCRATCH_ARB_STATS_EN
    output logic [31:0]          a_grant_cnt,
    output logic [31:0]          b_grant_cnt,
    output logic [31:0]          conflict_cnt,
`endif
    output logic                 scratch_read,
    output logic                 scratch_write,
    output logic [ADDR_BITS-1:0] scratch_addr,
    output logic [DATA_BITS-1:0] scratch_in,
    input  logic [DATA_BITS-1:0] scratch_out
);

    localparam int CNT_BITS = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    typedef enum logic {
        WIN_A = 1'b0,
        WIN_B = 1'b1
    } winner_t;

    owner_t                owner;
    winner_t               last_winner;
    logic [CNT_BITS-1:0]   burst_cnt;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DATA_BITS-1:0]  wdata_q;

    logic                  grant_a;
    logic                  grant_b;
    logic                  any_grant;
    logic                  burst_open;
    logic                  gnt_we;
    logic                  gnt_lock;
    owner_t                gnt_owner;
    logic [ADDR_BITS-1:0]  gnt_addr;
    logic [DATA_BITS-1:0]  gnt_wdata;

    // Grant decision. Held off while rst is high so the SRAM sees no access
    // during reset even if requesters keep their lines up.
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        burst_open = (burst_cnt < CNT_BITS'(MAX_BURST));
        if (!rst) begin
            if (owner == OWN_A && a_req && burst_open) begin
                grant_a = 1'b1;
            end else if (owner == OWN_B && b_req && burst_open) begin
                grant_b = 1'b1;
            end else if (a_req && b_req) begin
                // Saturated lock falls through here: the owner is last_winner,
                // so the waiting port wins the tie.
                if (last_winner == WIN_B) grant_a = 1'b1;
                else                      grant_b = 1'b1;
            end else if (a_req) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end
        end
    end

    assign any_grant = grant_a | grant_b;
    assign gnt_we    = grant_a ? a_we    : b_we;
    assign gnt_lock  = grant_a ? a_lock  : b_lock;
    assign gnt_addr  = grant_a ? a_addr  : b_addr;
    assign gnt_wdata = grant_a ? a_wdata : b_wdata;
    assign gnt_owner = grant_a ? OWN_A   : OWN_B;

    assign a_grant       = grant_a;
    assign b_grant       = grant_b;
    assign scratch_write = any_grant &  gnt_we;
    assign scratch_read  = any_grant & ~gnt_we;
    // Address/data are passed through in the grant cycle (the SRAM read is
    // combinational) and held from the last grant otherwise.
    assign scratch_addr  = any_grant ? gnt_addr  : addr_q;
    assign scratch_in    = any_grant ? gnt_wdata : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= OWN_NONE;
            last_winner <= WIN_B;
            burst_cnt   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            a_rvalid <= grant_a & ~a_we;
            b_rvalid <= grant_b & ~b_we;
            if (grant_a && !a_we) a_rdata <= scratch_out;
            if (grant_b && !b_we) b_rdata <= scratch_out;

            if (any_grant) begin
                addr_q      <= gnt_addr;
                wdata_q     <= gnt_wdata;
                last_winner <= grant_a ? WIN_A : WIN_B;
                if (gnt_lock) begin
                    owner <= gnt_owner;
                    if (owner == gnt_owner) begin
                        if (burst_cnt != CNT_BITS'(MAX_BURST))
                            burst_cnt <= burst_cnt + CNT_BITS'(1);
                    end else begin
                        burst_cnt <= CNT_BITS'(1);
                    end
                end else begin
                    owner     <= OWN_NONE;
                    burst_cnt <= '0;
                end
            end else begin
                owner     <= OWN_NONE;
                burst_cnt <= '0;
            end
        end
    end

`ifdef SCRYPT_SCRATCH_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_grant_cnt  <= '0;
            b_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant_a)         a_grant_cnt  <= a_grant_cnt + 32'd1;
            if (grant_b)         b_grant_cnt  <= b_grant_cnt + 32'd1;
            if (a_req && b_req)  conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scrypt_scratch_arbiter.sv
// Testbench for scrypt_scratch_arbiter: directed scenarios plus a randomized
// phase, checked by a scoreboard against a behavioural model of the arbiter
// and a reference copy of the scratchpad contents.
module tb_scrypt_scratch_arbiter;

    localparam int AB = 17;
    localparam int DB = 1024;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AB-1:0] a_addr, b_addr;
    logic [DB-1:0] a_wdata, b_wdata;
    logic          a_grant, a_rvalid, b_grant, b_rvalid;
    logic [DB-1:0] a_rdata, b_rdata;
    logic          scratch_read, scratch_write;
    logic [AB-1:0] scratch_addr;
    logic [DB-1:0] scratch_in, scratch_out;
`ifdef SCRYPT_SCRATCH_ARB_STATS_EN
    logic [31:0]   a_grant_cnt, b_grant_cnt, conflict_cnt;
`endif

    scrypt_scratch_arbiter #(
        .ADDR_BITS(AB),
        .DATA_BITS(DB),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_grant(a_grant), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_grant(b_grant), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef SCRYPT_SCRATCH_ARB_STATS_EN
        .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
        .scratch_read(scratch_read), .scratch_write(scratch_write),
        .scratch_addr(scratch_addr), .scratch_in(scratch_in), .scratch_out(scratch_out)
    );

    always #5 clk = ~clk;

    // Small SRAM behind the arbiter (low 5 address bits), cleared on reset.
    logic [DB-1:0] sram [0:31];
    assign scratch_out = sram[scratch_addr[4:0]];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) sram[i] <= '0;
        end else if (scratch_write) begin
            sram[scratch_addr[4:0]] <= scratch_in;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int            g;      // 0 none, 1 A, 2 B
        logic          rva, rvb, rd, wr;
        logic [AB-1:0] addr;
        logic [DB-1:0] wdata, rda, rdb;
        int            ca, cb, cc;
    } rec_t;

    rec_t          rec_q[$];
    logic [DB-1:0] rdq_a[$];
    logic [DB-1:0] rdq_b[$];
    int            act_hist[$];

    int checks = 0;
    int passes = 0;

    task automatic tally(input string name, input logic ok, input string act, input string exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %s, expected %s", name, act, exp);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        tally(name, act === exp, $sformatf("%b", act), $sformatf("%b", exp));
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        tally(name, act == exp, $sformatf("%0d", act), $sformatf("%0d", exp));
    endtask

    task automatic chka(input string name, input logic [AB-1:0] act, input logic [AB-1:0] exp);
        tally(name, act === exp, $sformatf("%h", act), $sformatf("%h", exp));
    endtask

    task automatic chkw(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        tally(name, act === exp, $sformatf("[127:0] %h", act[127:0]),
              $sformatf("[127:0] %h", exp[127:0]));
    endtask

    // Monitor: one record per driven cycle, compared away from the edge.
    always @(negedge clk) begin
        rec_t r;
        if (!rst && rec_q.size() > 0) begin
            r = rec_q.pop_front();
            act_hist.push_back(a_grant ? 1 : (b_grant ? 2 : 0));
            chkb("a_grant", a_grant, r.g == 1);
            chkb("b_grant", b_grant, r.g == 2);
            chkb("scratch_read", scratch_read, r.rd);
            chkb("scratch_write", scratch_write, r.wr);
            chka("scratch_addr", scratch_addr, r.addr);
            chkw("scratch_in", scratch_in, r.wdata);
            chkb("a_rvalid", a_rvalid, r.rva);
            chkb("b_rvalid", b_rvalid, r.rvb);
            chkw("a_rdata_hold", a_rdata, r.rda);
            chkw("b_rdata_hold", b_rdata, r.rdb);
            if (a_rvalid) begin
                if (rdq_a.size() == 0) chkn("a_rvalid_unexpected", 1, 0);
                else chkw("a_read_return", a_rdata, rdq_a.pop_front());
            end
            if (b_rvalid) begin
                if (rdq_b.size() == 0) chkn("b_rvalid_unexpected", 1, 0);
                else chkw("b_read_return", b_rdata, rdq_b.pop_front());
            end
`ifdef SCRYPT_SCRATCH_ARB_STATS_EN
            chkn("a_grant_cnt", int'(a_grant_cnt), r.ca);
            chkn("b_grant_cnt", int'(b_grant_cnt), r.cb);
            chkn("conflict_cnt", int'(conflict_cnt), r.cc);
`endif
        end
    end

    // ---------------- reference model ----------------
    int            m_last;      // last winner: 1 A, 2 B
    int            m_holder;    // port holding a lock: 0 none, 1 A, 2 B
    int            m_streak;    // consecutive locked grants to m_holder
    logic [AB-1:0] m_addr;
    logic [DB-1:0] m_data, m_rda, m_rdb;
    logic          m_pend_a, m_pend_b;
    logic [DB-1:0] ref_mem [0:31];
    int            m_ca, m_cb, m_cc;

    task automatic model_reset();
        m_last = 2; m_holder = 0; m_streak = 0;
        m_addr = '0; m_data = '0; m_rda = '0; m_rdb = '0;
        m_pend_a = 1'b0; m_pend_b = 1'b0;
        m_ca = 0; m_cb = 0; m_cc = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        rec_q.delete(); rdq_a.delete(); rdq_b.delete();
    endtask

    function automatic logic [DB-1:0] rand_word();
        logic [DB-1:0] w;
        for (int i = 0; i < DB / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Drive one cycle (called at posedge+1), predict it, then advance a clock.
    task automatic step(input logic ar, input logic aw, input logic al,
                        input logic [AB-1:0] aad, input logic [DB-1:0] ad,
                        input logic br, input logic bw, input logic bl,
                        input logic [AB-1:0] bad, input logic [DB-1:0] bd,
                        output int g);
        rec_t          r;
        logic          gwe, glk;
        logic [AB-1:0] gad;
        logic [DB-1:0] gd;
        a_req = ar; a_we = aw; a_lock = al; a_addr = aad; a_wdata = ad;
        b_req = br; b_we = bw; b_lock = bl; b_addr = bad; b_wdata = bd;

        if (m_holder == 1 && ar && m_streak < MB)      g = 1;
        else if (m_holder == 2 && br && m_streak < MB) g = 2;
        else if (ar && br)                             g = (m_last == 1) ? 2 : 1;
        else if (ar)                                   g = 1;
        else if (br)                                   g = 2;
        else                                           g = 0;

        gwe = (g == 1) ? aw : bw;
        glk = (g == 1) ? al : bl;
        gad = (g == 1) ? aad : bad;
        gd  = (g == 1) ? ad : bd;

        r.g = g; r.rva = m_pend_a; r.rvb = m_pend_b; r.rda = m_rda; r.rdb = m_rdb;
        r.rd = (g != 0) && !gwe;
        r.wr = (g != 0) && gwe;
        if (g != 0) begin m_addr = gad; m_data = gd; end
        r.addr = m_addr; r.wdata = m_data;
        r.ca = m_ca; r.cb = m_cb; r.cc = m_cc;
        rec_q.push_back(r);

        if (g == 1) m_ca++;
        if (g == 2) m_cb++;
        if (ar && br) m_cc++;

        m_pend_a = (g == 1) && !gwe;
        m_pend_b = (g == 2) && !gwe;
        if (m_pend_a) begin m_rda = ref_mem[gad[4:0]]; rdq_a.push_back(m_rda); end
        if (m_pend_b) begin m_rdb = ref_mem[gad[4:0]]; rdq_b.push_back(m_rdb); end
        if (r.wr) ref_mem[gad[4:0]] = gd;

        if (g == 0) begin
            m_holder = 0; m_streak = 0;
        end else begin
            if (glk) begin
                m_streak = (m_holder == g) ? ((m_streak < MB) ? m_streak + 1 : MB) : 1;
                m_holder = g;
            end else begin
                m_holder = 0; m_streak = 0;
            end
            m_last = g;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, g);
    endtask

    // Reset with requests held high: nothing may be granted during reset.
    task automatic do_reset();
        int g;
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b0;
        a_lock = 1'b0; b_lock = 1'b0;
        a_addr = 17'h00005; b_addr = 17'h00006; a_wdata = '1; b_wdata = '1;
        model_reset();
        @(posedge clk);
        #1;
        chkb("rst_a_grant", a_grant, 1'b0);
        chkb("rst_b_grant", b_grant, 1'b0);
        chkb("rst_scratch_read", scratch_read, 1'b0);
        chkb("rst_scratch_write", scratch_write, 1'b0);
        chka("rst_scratch_addr", scratch_addr, '0);
        chkw("rst_scratch_in", scratch_in, '0);
        chkb("rst_a_rvalid", a_rvalid, 1'b0);
        chkw("rst_a_rdata", a_rdata, '0);
        chkb("rst_b_rvalid", b_rvalid, 1'b0);
        chkw("rst_b_rdata", b_rdata, '0);
        g = 0;
        rst = 1'b0;
        act_hist.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            g, n_a;
        logic [DB-1:0] pat;
        logic          ar, aw, al, br, bw, bl, hold_a, hold_b;
        logic [AB-1:0] aad, bad;
        logic [DB-1:0] ad, bd;
        int            exp_tie  [4]  = '{1, 2, 1, 2};
        int            exp_lock [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

        rst = 1'b1;
        do_reset();

        // Tie after reset: A first, then strict alternation.
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 17'h00003, '0, 1, 0, 0, 17'h00004, '0, g);
        idle(1);
        for (int i = 0; i < 4; i++) chkn($sformatf("tie_grant%0d", i), act_hist[i], exp_tie[i]);

        // Write then read, A only.
        do_reset();
        pat = {32{32'hDEADBEEF}};
        step(1, 1, 0, 17'h00010, pat, 0, 0, 0, '0, '0, g);
        step(1, 0, 0, 17'h00010, '0, 0, 0, 0, '0, '0, g);
        chkb("wr_rd_a_rvalid", a_rvalid, 1'b1);
        chkw("wr_rd_a_rdata", a_rdata, pat);
        chkb("wr_rd_b_rvalid", b_rvalid, 1'b0);
        idle(1);
        chkb("wr_rd_a_rvalid_drop", a_rvalid, 1'b0);
        chkn("wr_rd_grant0", act_hist[0], 1);
        chkn("wr_rd_grant1", act_hist[1], 1);

        // Lock with contention: 4 A, 1 B, 4 A, 1 B.
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1, 1, 1, AB'(i), rand_word(), 1, 0, 0, 17'h00007, '0, g);
        idle(1);
        for (int i = 0; i < 10; i++) chkn($sformatf("lock_grant%0d", i), act_hist[i], exp_lock[i]);

        // Lock without contention: A keeps every grant past saturation.
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1, 0, 1, AB'(i), '0, 0, 0, 0, '0, '0, g);
        idle(1);
        n_a = 0;
        for (int i = 0; i < 20; i++) if (act_hist[i] == 1) n_a++;
        chkn("lock_solo_a_grants", n_a, 20);
        // After saturation a competitor must win next.
        step(1, 0, 1, '0, '0, 0, 0, 0, '0, '0, g);
        step(1, 0, 1, '0, '0, 0, 0, 0, '0, '0, g);
        step(1, 0, 1, '0, '0, 0, 0, 0, '0, '0, g);
        step(1, 0, 1, '0, '0, 0, 0, 0, '0, '0, g);
        act_hist.delete();
        step(1, 0, 1, '0, '0, 1, 0, 0, '0, '0, g);
        idle(1);
        chkn("lock_forced_release", act_hist[0], 2);

        // Randomized traffic with hold-until-grant requesters.
        do_reset();
        hold_a = 1'b0; hold_b = 1'b0;
        ar = 0; aw = 0; al = 0; aad = '0; ad = '0;
        br = 0; bw = 0; bl = 0; bad = '0; bd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold_a) begin
                ar = ($urandom_range(0, 9) < 6); aw = 1'($urandom_range(0, 1));
                al = ($urandom_range(0, 9) < 3); aad = AB'($urandom_range(0, 31));
                ad = rand_word();
            end
            if (!hold_b) begin
                br = ($urandom_range(0, 9) < 6); bw = 1'($urandom_range(0, 1));
                bl = ($urandom_range(0, 9) < 3); bad = AB'($urandom_range(0, 31));
                bd = rand_word();
            end
            step(ar, aw, al, aad, ad, br, bw, bl, bad, bd, g);
            hold_a = ar && (g != 1);
            hold_b = br && (g != 2);
        end
        idle(2);
        chkn("rand_rdq_a_drained", rdq_a.size(), 0);
        chkn("rand_rdq_b_drained", rdq_b.size(), 0);

        // Reset in the cycle after a granted A read.
        do_reset();
        step(1, 1, 1, 17'h00010, pat, 0, 0, 0, '0, '0, g);
        step(1, 0, 1, 17'h00010, '0, 0, 0, 0, '0, '0, g);
        chkb("pre_rst_a_rvalid", a_rvalid, 1'b1);
        rst = 1'b1;
        #1;
        chkb("midrst_a_rvalid", a_rvalid, 1'b0);
        chkw("midrst_a_rdata", a_rdata, '0);
        do_reset();

        // Dual requests then A alone (also exercises the grant counters).
        for (int i = 0; i < 8; i++)
            step(1, 0, 0, 17'h00001, '0, 1, 0, 0, 17'h00002, '0, g);
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 17'h00001, '0, 0, 0, 0, '0, '0, g);
        chkn("post_rst_first_grant", act_hist[0], 1);
`ifdef SCRYPT_SCRATCH_ARB_STATS_EN
        chkn("stats_conflict", int'(conflict_cnt), 8);
        chkn("stats_a", int'(a_grant_cnt), 7);
        chkn("stats_b", int'(b_grant_cnt), 4);
`endif
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/scrypt_scratch_arbiter.md
Name: scrypt_scratch_arbiter

Overview:
- Shares the single on-chip scratchpad SRAM (17-bit address, 1024-bit word) between two requesters.
- Port A is the scrypt_smix core's scratch interface; port B is the host/debug loader used to preload and inspect the V array.
- Round-robin arbitration with optional burst locking; one SRAM access per cycle; registered read return.

Parameters:
- ADDR_BITS, 17, scratchpad address width
- DATA_BITS, 1024, scratchpad word width (one 128-byte smix block)
- MAX_BURST, 16, maximum consecutive locked grants before a forced hand-over (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- a_req  in  1  port A access request (smix)
- a_we  in  1  port A: 1=write, 0=read
- a_lock  in  1  port A requests to keep ownership next cycle
- a_addr  in  ADDR_BITS  port A address
- a_wdata  in  DATA_BITS  port A write data
- a_grant  out  1  port A access performed this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DATA_BITS  port A read data
- b_req, b_we, b_lock, b_addr, b_wdata, b_grant, b_rvalid, b_rdata: same as port A, for port B
- scratch_read  out  1  SRAM read_enable
- scratch_write  out  1  SRAM write_enable
- scratch_addr  out  ADDR_BITS  SRAM address
- scratch_in  out  DATA_BITS  SRAM write_data
- scratch_out  in  DATA_BITS  SRAM read_data (combinational from address)

Behaviour:
- Reset (async, rst=1): a_grant=b_grant=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, scratch_read=scratch_write=0, scratch_addr=0, scratch_in=0, last_winner=B (A wins first tie), owner=NONE, burst_cnt=0.
- Grant is combinational in the request cycle. Exactly one of a_grant/b_grant is high when any req is high; neither is high otherwise.
- Decision order:
  - (1) If an owner is locked, that owner is still requesting, and burst_cnt<MAX_BURST: grant owner.
  - (2) Else if only one port requests: grant it.
  - (3) Else if both request: grant the port that is not last_winner.
- A lock is forced released when burst_cnt reaches MAX_BURST and the other port is requesting; the other port then wins case (3).
- SRAM drive:
  - Granted port's addr/wdata go to scratch_addr/scratch_in.
  - scratch_write = grant & we; scratch_read = grant & ~we.
  - With no grant: read=write=0, addr and data hold their last values.
- Read return:
  - On the clock edge of a granted read, scratch_out is registered into the granted port's rdata; that port's rvalid=1 for exactly the next cycle.
  - rdata holds until the next read for that port.
  - Writes never raise rvalid.
- State registers, updated each edge with a grant:
  - last_winner <= granted port.
  - If granted port's lock=1: owner <= granted port; burst_cnt <= burst_cnt+1 if owner is unchanged, else 1.
  - If lock=0: owner <= NONE, burst_cnt <= 0.
- No grant in a cycle: owner <= NONE, burst_cnt <= 0. last_winner is held.
- burst_cnt saturates at MAX_BURST. With MAX_BURST reached and no competitor, the owner keeps being granted.
- Requesters hold req/we/addr/wdata stable until they see grant.
- Reset mid-operation: any pending rvalid is dropped and the lock is cleared. The first access after reset obeys the tie rule (A first).

Optional Feature:
- Macro: SCRYPT_SCRATCH_ARB_STATS_EN.
- Defined: adds outputs a_grant_cnt[31:0] and b_grant_cnt[31:0] (grants per port, wrap at 2^32) and conflict_cnt[31:0] (cycles with both req high). All three reset to 0 and increment on the clock edge.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical.

Test Plan:
- Write then read, A only: a write of 0xDEADBEEF replicated at addr 0x00010, then a read of 0x00010 → a_grant each cycle; a_rvalid high one cycle after the read with identical data; b_* stay 0.
- Tie after reset: a_req=b_req=1 on the first cycle, no lock → grants go A,B,A,B alternately; each port sees rvalid only for its own reads.
- Lock with MAX_BURST=4: A holds lock=1 and req for 10 cycles while B requests continuously → A granted 4 cycles, B 1, A 4, B 1.
- Lock without contention: A locked for 20 cycles, B idle → A granted all 20 cycles; burst_cnt saturates at 4.
- Reset mid-read: assert rst in the cycle after a granted A read → a_rvalid=0, a_rdata=0 immediately; after release, simultaneous requests grant A first.
- Stats (macro on): 8 cycles of dual requests then 3 cycles of A alone → conflict_cnt=8, a_grant_cnt=7, b_grant_cnt=4.
